multicycle_ctrl: RTL and testbench

Multicycle control FSM that sequences the processor datapath: fetch, decode/register-read, execute, memory and writeback stages.
- Decodes Instr[31:26] and Instr[5:0].
- Drives every datapath control line: PC, instruction register, register file, ALU, data memory and immediate extender.
- Sits beside the datapath top level. Sole owner of RF_WrEn, RF_WrData_sel and RF_B_sel.

---
 rtl/multicycle_ctrl.sv | 326 ++++++++++++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// multicycle_ctrl
//
// Control FSM for the multicycle processor datapath. Walks every instruction
// through fetch, decode/register-read, execute, memory and writeback, and
// drives all datapath control lines as Moore outputs of the current state
// plus the opcode/func captured while in S_DEC.
//
// Optional feature (compile-time macro CTRL_MEM_WAIT_EN):
//   When defined, adds input Mem_Ready; S_MEM_RD and S_MEM_WR hold until
//   Mem_Ready=1, with address controls, ByteOp and Mem_WrEn kept stable.
//   When undefined there is no Mem_Ready port and memory states last one cycle.
//
// Ports:
//   Clk            in   system clock, rising edge
//   Reset          in   synchronous, active-high
//   Instr[31:0]    in   instruction register contents
//   Zero           in   ALU zero flag, sampled in S_EXEC
//   Mem_Ready      in   memory handshake (CTRL_MEM_WAIT_EN only)
//   PC_LdEn        out  PC load enable (one cycle per instruction)
//   PC_sel         out  0 = PC+4, 1 = PC+4+(Immed<<2)
//   IR_LdEn        out  instruction register load
//   RF_WrEn        out  register file write enable
//   RF_WrData_sel  out  0 = ALU_out, 1 = MEM_out
//   RF_B_sel       out  0 = Instr[15:11], 1 = Instr[20:16]
//   ImmExt[1:0]    out  00 sign-ext, 01 zero-ext, 10 shift-left-16
//   ALU_Bin_sel    out  0 = RF_B, 1 = Immed
//   ALU_func[3:0]  out  ALU operation code
//   Mem_WrEn       out  data memory write
//   ByteOp         out  1 = byte access (lb/sb)
//   State[3:0]     out  current state encoding (debug)
//   Instr_Retired  out  retired-instruction counter, wraps mod 2^CNT_W
// -----------------------------------------------------------------------------
module multicycle_ctrl #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [31:0]      Instr,
  input  logic             Zero,
`ifdef CTRL_MEM_WAIT_EN
  input  logic             Mem_Ready,
`endif
  output logic             PC_LdEn,
  output logic             PC_sel,
  output logic             IR_LdEn,
  output logic             RF_WrEn,
  output logic             RF_WrData_sel,
  output logic             RF_B_sel,
  output logic [1:0]       ImmExt,
  output logic             ALU_Bin_sel,
  output logic [3:0]       ALU_func,
  output logic             Mem_WrEn,
  output logic             ByteOp,
  output logic [3:0]       State,
  output logic [CNT_W-1:0] Instr_Retired
);

  // State encoding
  localparam logic [3:0] S_IF     = 4'd0;
  localparam logic [3:0] S_DEC    = 4'd1;
  localparam logic [3:0] S_EXEC   = 4'd2;
  localparam logic [3:0] S_MEM_RD = 4'd3;
  localparam logic [3:0] S_MEM_WR = 4'd4;
  localparam logic [3:0] S_WB_ALU = 4'd5;
  localparam logic [3:0] S_WB_MEM = 4'd6;
  localparam logic [3:0] S_BR     = 4'd7;

  // Opcodes
  localparam logic [5:0] OP_RTYPE = 6'b100000;
  localparam logic [5:0] OP_LI    = 6'b111000;
  localparam logic [5:0] OP_LUI   = 6'b111001;
  localparam logic [5:0] OP_ADDI  = 6'b110000;
  localparam logic [5:0] OP_ANDI  = 6'b110010;
  localparam logic [5:0] OP_ORI   = 6'b110011;
  localparam logic [5:0] OP_LB    = 6'b000011;
  localparam logic [5:0] OP_LW    = 6'b001111;
  localparam logic [5:0] OP_SB    = 6'b000111;
  localparam logic [5:0] OP_SW    = 6'b011111;
  localparam logic [5:0] OP_BEQ   = 6'b010000;
  localparam logic [5:0] OP_BNE   = 6'b010001;
  localparam logic [5:0] OP_B     = 6'b111111;

  // ALU operations and immediate extension modes
  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [1:0] IMM_SEXT = 2'b00;
  localparam logic [1:0] IMM_ZEXT = 2'b01;
  localparam logic [1:0] IMM_HI16 = 2'b10;

  logic [3:0]       state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [5:0]       func_q, func_d;
  logic             zero_q, zero_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic mem_ready;

`ifdef CTRL_MEM_WAIT_EN
  assign mem_ready = Mem_Ready;
`else
  assign mem_ready = 1'b1;
`endif

  // Only the opcode and func fields are decoded here.
  logic unused_instr;
  assign unused_instr = ^Instr[25:6];

  // ---------------------------------------------------------------------------
  // Opcode/func source: live Instr while in S_DEC (the IR has just been
  // loaded), the captured copy in every later state.
  // ---------------------------------------------------------------------------
  logic [5:0] op_cur;
  logic [5:0] func_cur;

  assign op_cur   = (state_q == S_DEC) ? Instr[31:26] : op_q;
  assign func_cur = (state_q == S_DEC) ? Instr[5:0]   : func_q;

  logic is_rtype, is_ialu, is_load, is_store, is_beq, is_bne, is_b, is_legal;
  logic is_byte, use_rt_b, func_legal;

  always_comb begin
    is_rtype = (op_cur == OP_RTYPE);
    is_ialu  = (op_cur == OP_LI)   || (op_cur == OP_LUI) || (op_cur == OP_ADDI) ||
               (op_cur == OP_ANDI) || (op_cur == OP_ORI);
    is_load  = (op_cur == OP_LB)   || (op_cur == OP_LW);
    is_store = (op_cur == OP_SB)   || (op_cur == OP_SW);
    is_beq   = (op_cur == OP_BEQ);
    is_bne   = (op_cur == OP_BNE);
    is_b     = (op_cur == OP_B);
    is_legal = is_rtype || is_ialu || is_load || is_store || is_beq || is_bne;
    is_byte  = (op_cur == OP_LB)   || (op_cur == OP_SB);
    // Stores need rt as write data; branches compare rs with rt.
    use_rt_b = is_store || is_beq || is_bne;
    func_legal = ((func_cur >= 6'b110000) && (func_cur <= 6'b110100)) ||
                 ((func_cur >= 6'b111000) && (func_cur <= 6'b111101));
  end

  // ALU/immediate setup for the captured instruction; gated by state below.
  logic       alu_bin_sel;
  logic [3:0] alu_func;
  logic [1:0] imm_ext;

  always_comb begin
    alu_bin_sel = 1'b0;
    alu_func    = ALU_ADD;
    imm_ext     = IMM_SEXT;
    unique case (op_cur)
      OP_RTYPE: alu_func = func_cur[3:0];
      OP_LI, OP_ADDI, OP_LB, OP_LW, OP_SB, OP_SW: alu_bin_sel = 1'b1;
      OP_LUI: begin
        alu_bin_sel = 1'b1;
        imm_ext     = IMM_HI16;
      end
      OP_ANDI: begin
        alu_bin_sel = 1'b1;
        alu_func    = ALU_AND;
        imm_ext     = IMM_ZEXT;
      end
      OP_ORI: begin
        alu_bin_sel = 1'b1;
        alu_func    = ALU_OR;
        imm_ext     = IMM_ZEXT;
      end
      OP_BEQ, OP_BNE: alu_func = ALU_SUB;
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = S_IF;
    unique case (state_q)
      S_IF:  state_d = S_DEC;
      S_DEC: begin
        // b and illegal opcodes both retire through S_BR; illegal ones with
        // PC_sel=0 so they behave as a NOP.
        if (is_b || !is_legal) begin
          state_d = S_BR;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_rtype || is_ialu) begin
          state_d = S_WB_ALU;
        end else if (is_load) begin
          state_d = S_MEM_RD;
        end else if (is_store) begin
          state_d = S_MEM_WR;
        end else if (is_beq || is_bne) begin
          state_d = S_BR;
        end else begin
          state_d = S_IF;
        end
      end
      S_MEM_RD: state_d = mem_ready ? S_WB_MEM : S_MEM_RD;
      S_MEM_WR: state_d = mem_ready ? S_IF : S_MEM_WR;
      S_WB_ALU, S_WB_MEM, S_BR: state_d = S_IF;
      default: state_d = S_IF;
    endcase
  end

  assign op_d   = (state_q == S_DEC)  ? Instr[31:26] : op_q;
  assign func_d = (state_q == S_DEC)  ? Instr[5:0]   : func_q;
  assign zero_d = (state_q == S_EXEC) ? Zero         : zero_q;

  // ---------------------------------------------------------------------------
  // Moore outputs. Everything is forced to its reset value while Reset is
  // high so an aborted instruction cannot write RF, memory or PC in the
  // reset cycle itself.
  // ---------------------------------------------------------------------------
  logic       pc_ld_en, pc_sel, ir_ld_en, rf_wr_en, rf_wr_data_sel, rf_b_sel;
  logic       mem_wr_en, byte_op, o_alu_bin_sel;
  logic [3:0] o_alu_func;
  logic [1:0] o_imm_ext;

  always_comb begin
    pc_ld_en       = 1'b0;
    pc_sel         = 1'b0;
    ir_ld_en       = 1'b0;
    rf_wr_en       = 1'b0;
    rf_wr_data_sel = 1'b0;
    rf_b_sel       = 1'b0;
    mem_wr_en      = 1'b0;
    byte_op        = 1'b0;
    o_alu_bin_sel  = 1'b0;
    o_alu_func     = ALU_ADD;
    o_imm_ext      = IMM_SEXT;
    if (!Reset) begin
      unique case (state_q)
        S_IF:  ir_ld_en = 1'b1;
        S_DEC: rf_b_sel = use_rt_b;
        S_EXEC: begin
          rf_b_sel      = use_rt_b;
          o_alu_bin_sel = alu_bin_sel;
          o_alu_func    = alu_func;
          o_imm_ext     = imm_ext;
        end
        S_MEM_RD: begin
          // Keep the address computation stable while memory is accessed.
          o_alu_bin_sel = alu_bin_sel;
          o_alu_func    = alu_func;
          o_imm_ext     = imm_ext;
          byte_op       = is_byte;
        end
        S_MEM_WR: begin
          rf_b_sel      = 1'b1;
          o_alu_bin_sel = alu_bin_sel;
          o_alu_func    = alu_func;
          o_imm_ext     = imm_ext;
          byte_op       = is_byte;
          mem_wr_en     = 1'b1;
          pc_ld_en      = mem_ready;
        end
        S_WB_ALU: begin
          o_alu_bin_sel = alu_bin_sel;
          o_alu_func    = alu_func;
          o_imm_ext     = imm_ext;
          // R-type with an undefined func retires without a register write.
          rf_wr_en      = !is_rtype || func_legal;
          pc_ld_en      = 1'b1;
        end
        S_WB_MEM: begin
          byte_op        = is_byte;
          rf_wr_en       = 1'b1;
          rf_wr_data_sel = 1'b1;
          pc_ld_en       = 1'b1;
        end
        S_BR: begin
          pc_ld_en = 1'b1;
          if (is_b) begin
            pc_sel = 1'b1;
          end else if (is_beq) begin
            pc_sel = zero_q;
          end else if (is_bne) begin
            pc_sel = !zero_q;
          end else begin
            pc_sel = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign cnt_d = pc_ld_en ? (cnt_q + CNT_W'(1)) : cnt_q;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IF;
      op_q    <= '0;
      func_q  <= '0;
      zero_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      func_q  <= func_d;
      zero_q  <= zero_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC_LdEn       = pc_ld_en;
  assign PC_sel        = pc_sel;
  assign IR_LdEn       = ir_ld_en;
  assign RF_WrEn       = rf_wr_en;
  assign RF_WrData_sel = rf_wr_data_sel;
  assign RF_B_sel      = rf_b_sel;
  assign ImmExt        = o_imm_ext;
  assign ALU_Bin_sel   = o_alu_bin_sel;
  assign ALU_func      = o_alu_func;
  assign Mem_WrEn      = mem_wr_en;
  assign ByteOp        = byte_op;
  assign State         = state_q;
  assign Instr_Retired = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// -----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Self-checking bench for multicycle_ctrl. Directed instructions from the
// test plan followed by randomized instructions, resets and Zero values. The
// reference model classifies each instruction, builds its expected stage list
// and derives per-stage control values from the instruction-level rules.
// Uses a narrow retired counter so wrap-around is exercised.
// -----------------------------------------------------------------------------
module tb_multicycle_ctrl;

  localparam int unsigned CNT_W = 4;

  localparam int S_IF     = 0;
  localparam int S_DEC    = 1;
  localparam int S_EXEC   = 2;
  localparam int S_MEM_RD = 3;
  localparam int S_MEM_WR = 4;
  localparam int S_WB_ALU = 5;
  localparam int S_WB_MEM = 6;
  localparam int S_BR     = 7;

  localparam int K_RTYPE = 0;
  localparam int K_IALU  = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;
  localparam int K_BEQ   = 4;
  localparam int K_BNE   = 5;
  localparam int K_B     = 6;
  localparam int K_ILL   = 7;

  logic             Clk;
  logic             Reset;
  logic [31:0]      Instr;
  logic             Zero;
`ifdef CTRL_MEM_WAIT_EN
  logic             Mem_Ready;
`endif
  logic             PC_LdEn;
  logic             PC_sel;
  logic             IR_LdEn;
  logic             RF_WrEn;
  logic             RF_WrData_sel;
  logic             RF_B_sel;
  logic [1:0]       ImmExt;
  logic             ALU_Bin_sel;
  logic [3:0]       ALU_func;
  logic             Mem_WrEn;
  logic             ByteOp;
  logic [3:0]       State;
  logic [CNT_W-1:0] Instr_Retired;

  multicycle_ctrl #(
    .CNT_W(CNT_W)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .Instr        (Instr),
    .Zero         (Zero),
`ifdef CTRL_MEM_WAIT_EN
    .Mem_Ready    (Mem_Ready),
`endif
    .PC_LdEn      (PC_LdEn),
    .PC_sel       (PC_sel),
    .IR_LdEn      (IR_LdEn),
    .RF_WrEn      (RF_WrEn),
    .RF_WrData_sel(RF_WrData_sel),
    .RF_B_sel     (RF_B_sel),
    .ImmExt       (ImmExt),
    .ALU_Bin_sel  (ALU_Bin_sel),
    .ALU_func     (ALU_func),
    .Mem_WrEn     (Mem_WrEn),
    .ByteOp       (ByteOp),
    .State        (State),
    .Instr_Retired(Instr_Retired)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  int n_checks = 0;
  int n_pass   = 0;
  int retired  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int classify(input logic [5:0] op);
    case (op)
      6'b100000:                                     return K_RTYPE;
      6'b111000, 6'b111001, 6'b110000,
      6'b110010, 6'b110011:                          return K_IALU;
      6'b000011, 6'b001111:                          return K_LOAD;
      6'b000111, 6'b011111:                          return K_STORE;
      6'b010000:                                     return K_BEQ;
      6'b010001:                                     return K_BNE;
      6'b111111:                                     return K_B;
      default:                                       return K_ILL;
    endcase
  endfunction

  function automatic bit func_ok(input logic [5:0] fn);
    int v;
    v = int'(fn);
    return (v >= 48 && v <= 52) || (v >= 56 && v <= 61);
  endfunction

  // Expected {ALU_Bin_sel, ALU_func, ImmExt} during execute.
  function automatic logic [6:0] exp_alu(input logic [5:0] op, input logic [5:0] fn);
    case (op)
      6'b100000: return {1'b0, fn[3:0], 2'b00};
      6'b111000: return {1'b1, 4'b0000, 2'b00};
      6'b111001: return {1'b1, 4'b0000, 2'b10};
      6'b110000: return {1'b1, 4'b0000, 2'b00};
      6'b110010: return {1'b1, 4'b0010, 2'b01};
      6'b110011: return {1'b1, 4'b0011, 2'b01};
      6'b010000, 6'b010001: return {1'b0, 4'b0001, 2'b00};
      default:   return {1'b1, 4'b0000, 2'b00};
    endcase
  endfunction

  // Run one instruction from S_IF. zmode: 0/1 force Zero, 2 random.
  // rst_at: stage index at which Reset is asserted (-1 = none).
  task automatic run_instr(input logic [31:0] ins, input int zmode, input int rst_at);
    logic [5:0] op;
    logic [5:0] fn;
    int         k;
    int         st_q[$];
    int         w;
    int         mem_cnt;
    int         st;
    bit         zero_ex;
    bit         zv;
    bit         rdy;
    bit         in_rst;
    bit         e_pc_ld;
    bit         e_pc_sel;
    bit         e_rf_wr;
    bit         is_byte;
    bit         rt_b;
    op      = ins[31:26];
    fn      = ins[5:0];
    k       = classify(op);
    w       = 0;
    mem_cnt = 0;
    zero_ex = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    w = $urandom_range(0, 3);
`endif
    is_byte = (op == 6'b000011) || (op == 6'b000111);
    rt_b    = (k == K_STORE) || (k == K_BEQ) || (k == K_BNE);
    st_q = {S_IF, S_DEC};
    case (k)
      K_RTYPE, K_IALU: st_q.push_back(S_EXEC);
      K_LOAD, K_STORE, K_BEQ, K_BNE: st_q.push_back(S_EXEC);
      default: ;
    endcase
    case (k)
      K_RTYPE, K_IALU: st_q.push_back(S_WB_ALU);
      K_LOAD: begin
        for (int j = 0; j <= w; j++) st_q.push_back(S_MEM_RD);
        st_q.push_back(S_WB_MEM);
      end
      K_STORE: for (int j = 0; j <= w; j++) st_q.push_back(S_MEM_WR);
      default: st_q.push_back(S_BR);
    endcase

    for (int i = 0; i < st_q.size(); i++) begin
      st     = st_q[i];
      in_rst = (i == rst_at);
      rdy    = 1'b1;
      if (st == S_MEM_RD || st == S_MEM_WR) begin
        rdy = (mem_cnt == w);
        mem_cnt++;
      end
      zv    = (zmode == 2) ? 1'($urandom % 2) : (zmode == 1);
      // Fields after decode are scrambled: the DUT must use its captured copy.
      Instr = (i < 2) ? ins : $urandom;
      Zero  = zv;
      Reset = in_rst;
`ifdef CTRL_MEM_WAIT_EN
      Mem_Ready = rdy;
`endif
      @(negedge Clk);
      check_eq($sformatf("state[%0d]", i), 32'(State), 32'(st));
      if (in_rst) begin
        check_eq("rst_cycle_outs",
                 {PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                  ImmExt, ALU_Bin_sel, ALU_func, Mem_WrEn, ByteOp}, 32'd0);
        @(posedge Clk);
        #1;
        Reset   = 1'b0;
        retired = 0;
        check_eq("rst_state", 32'(State), 32'(S_IF));
        check_eq("rst_retired", 32'(Instr_Retired), 32'd0);
        return;
      end
      e_pc_ld = (st == S_WB_ALU) || (st == S_WB_MEM) || (st == S_BR) ||
                (st == S_MEM_WR && rdy);
      e_pc_sel = 1'b0;
      if (st == S_BR) begin
        if (k == K_B)        e_pc_sel = 1'b1;
        else if (k == K_BEQ) e_pc_sel = zero_ex;
        else if (k == K_BNE) e_pc_sel = !zero_ex;
      end
      e_rf_wr = (st == S_WB_MEM) || (st == S_WB_ALU && !(k == K_RTYPE && !func_ok(fn)));
      check_eq("pc_ld", 32'(PC_LdEn), 32'(e_pc_ld));
      check_eq("pc_sel", 32'(PC_sel), 32'(e_pc_sel));
      check_eq("ir_ld", 32'(IR_LdEn), 32'(st == S_IF));
      check_eq("rf_wr", 32'(RF_WrEn), 32'(e_rf_wr));
      check_eq("mem_wr", 32'(Mem_WrEn), 32'(st == S_MEM_WR));
      if (e_rf_wr) check_eq("wrdata_sel", 32'(RF_WrData_sel), 32'(st == S_WB_MEM));
      if (st == S_DEC) check_eq("rf_b_sel", 32'(RF_B_sel), 32'(rt_b));
      if (st == S_EXEC) check_eq("alu_ctrl", 32'({ALU_Bin_sel, ALU_func, ImmExt}),
                                 32'(exp_alu(op, fn)));
      if (st == S_MEM_RD || st == S_MEM_WR) begin
        check_eq("byteop", 32'(ByteOp), 32'(is_byte));
        check_eq("mem_addr_ctrl", 32'({ALU_Bin_sel, ALU_func, ImmExt}), 32'(7'b1000000));
      end
      @(posedge Clk);
      #1;
      if (st == S_EXEC) zero_ex = zv;
      if (e_pc_ld) retired = (retired + 1) % (1 << CNT_W);
    end
    check_eq("retired", 32'(Instr_Retired), 32'(retired));
  endtask

  logic [5:0] op_tab [13] = '{6'b100000, 6'b111000, 6'b111001, 6'b110000, 6'b110010,
                              6'b110011, 6'b000011, 6'b001111, 6'b000111, 6'b011111,
                              6'b010000, 6'b010001, 6'b111111};
  logic [5:0] fn_tab [11] = '{6'h30, 6'h31, 6'h32, 6'h33, 6'h34, 6'h38, 6'h39, 6'h3a,
                              6'h3b, 6'h3c, 6'h3d};

  initial begin
    logic [31:0] ins;
    int          rst_at;
    Reset = 1'b1;
    Instr = '0;
    Zero  = 1'b0;
`ifdef CTRL_MEM_WAIT_EN
    Mem_Ready = 1'b1;
`endif
    for (int c = 0; c < 2; c++) begin
      @(posedge Clk);
      #1;
      @(negedge Clk);
      check_eq("reset_outs",
               {PC_LdEn, PC_sel, IR_LdEn, RF_WrEn, RF_WrData_sel, RF_B_sel,
                ImmExt, ALU_Bin_sel, ALU_func, Mem_WrEn, ByteOp}, 32'd0);
      check_eq("reset_state", 32'(State), 32'(S_IF));
    end
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    check_eq("reset_retired", 32'(Instr_Retired), 32'd0);

    // Directed instructions
    run_instr(32'h80221830, 2, -1);  // R-type add
    run_instr(32'h3C220004, 2, -1);  // lw
    run_instr(32'h40220002, 1, -1);  // beq taken
    run_instr(32'h40220002, 0, -1);  // beq not taken
    run_instr(32'h44220002, 0, -1);  // bne taken
    run_instr(32'h7C220008, 2, -1);  // sw
    run_instr(32'h0C220008, 2, -1);  // lb
    run_instr(32'h1C220008, 2, -1);  // sb
    run_instr(32'hFC000010, 2, -1);  // b
    run_instr(32'h04000000, 2, -1);  // illegal opcode
    run_instr(32'h8022183F, 2, -1);  // R-type, undefined func
    run_instr(32'hE4220005, 2, -1);  // lui
    run_instr(32'hC8220005, 2, -1);  // andi
    run_instr(32'hC0220005, 2, 2);   // addi, reset in execute
    run_instr(32'h80221832, 2, 3);   // R-type, reset in writeback

    // Randomized instructions, occasional resets
    for (int n = 0; n < 200; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 9) != 0) ins[31:26] = op_tab[$urandom_range(0, 12)];
      if ($urandom_range(0, 2) != 0) ins[5:0] = fn_tab[$urandom_range(0, 10)];
      rst_at = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 2)) : -1;
      run_instr(ins, 2, rst_at);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
